// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - opcodes, instruction field offsets and executor states
package dp_pkg;

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_DRAW     = 4'd1;
  localparam logic [3:0] OP_MEMREAD  = 4'd2;
  localparam logic [3:0] OP_MEMWRITE = 4'd3;
  localparam logic [3:0] OP_FILL     = 4'd4;
  localparam logic [3:0] OP_MEMADD   = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_RD_WAIT,
    S_WR,
    S_FILL,
    S_ADD_WAIT,
    S_ADD_WR
  } state_t;

  // Pixel fields are packed LSB first: x, y, colour, plot bit, then FILL count.
  function automatic int y_lsb(input int x_w);
    return x_w;
  endfunction

  function automatic int colour_lsb(input int x_w, input int y_w);
    return x_w + y_w;
  endfunction

  function automatic int plot_pos(input int x_w, input int y_w, input int c_w);
    return x_w + y_w + c_w;
  endfunction

  function automatic int count_lsb(input int x_w, input int y_w, input int c_w);
    return x_w + y_w + c_w + 1;
  endfunction

endpackage

// File: rtl/dp_decode.sv
// rtl/dp_decode.sv - combinational field extraction and legal-opcode check
module dp_decode
  import dp_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int CNT_W    = 8,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 12,
  parameter int INSTR_W  = 32
) (
  input  logic [INSTR_W-1:0]  instruction,
  output logic [3:0]          opcode,
  output logic                legal,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot_bit,
  output logic [CNT_W-1:0]    count,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   data
);

  localparam int YL = y_lsb(X_W);
  localparam int CL = colour_lsb(X_W, Y_W);
  localparam int PP = plot_pos(X_W, Y_W, COLOUR_W);
  localparam int NL = count_lsb(X_W, Y_W, COLOUR_W);

  logic unused_ok;

  assign opcode   = instruction[INSTR_W-1 -: 4];
  assign x        = instruction[0 +: X_W];
  assign y        = instruction[YL +: Y_W];
  assign colour   = instruction[CL +: COLOUR_W];
  assign plot_bit = instruction[PP];
  assign count    = instruction[NL +: CNT_W];
  assign addr     = instruction[0 +: ADDR_W];
  assign data     = instruction[ADDR_W +: DATA_W];
  assign unused_ok = ^instruction;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_NOP, OP_DRAW, OP_MEMREAD, OP_MEMWRITE, OP_FILL, OP_MEMADD: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - instruction executor driving the plotter port and external RAM
module instr_exec_unit
  import dp_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int CNT_W    = 8,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 12,
  parameter int RESULT_W = 16,
  parameter int INSTR_W  = 32,
  parameter int RD_LAT   = 2
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [INSTR_W-1:0]  instruction,
  output logic                finished,
  output logic                error,
  output logic [RESULT_W-1:0] result,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data,
  output logic                mem_write,
  input  logic [DATA_W-1:0]   mem_q
);

  localparam int CW = $clog2(RD_LAT + 1);

  state_t               state, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d, dec_in;
  logic [CW-1:0]        wait_cnt, wait_cnt_d;
  logic [CNT_W-1:0]     fill_cnt, fill_cnt_d;
  logic [X_W-1:0]       cur_x, cur_x_d;
  logic                 finished_d, error_d, plot_d, mem_write_d;
  logic [RESULT_W-1:0]  result_d;
  logic [X_W-1:0]       x_d;
  logic [Y_W-1:0]       y_d;
  logic [COLOUR_W-1:0]  colour_d;
  logic [ADDR_W-1:0]    mem_address_d;
  logic [DATA_W-1:0]    mem_data_d;

  logic [3:0]           f_op;
  logic                 f_legal, f_plot;
  logic [X_W-1:0]       f_x;
  logic [Y_W-1:0]       f_y;
  logic [COLOUR_W-1:0]  f_colour;
  logic [CNT_W-1:0]     f_count;
  logic [ADDR_W-1:0]    f_addr;
  logic [DATA_W-1:0]    f_data;
  logic [DATA_W-1:0]    sum;

  // The live input is decoded only while waiting for a request; afterwards the latched copy is used.
  assign dec_in = (state == S_IDLE && finished) ? instruction : instr_q;
  assign sum    = mem_q + f_data;

  dp_decode #(
    .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .CNT_W(CNT_W),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)
  ) u_decode (
    .instruction(dec_in),
    .opcode     (f_op),
    .legal      (f_legal),
    .x          (f_x),
    .y          (f_y),
    .colour     (f_colour),
    .plot_bit   (f_plot),
    .count      (f_count),
    .addr       (f_addr),
    .data       (f_data)
  );

  always_comb begin
    state_d       = state;
    instr_d       = instr_q;
    wait_cnt_d    = wait_cnt;
    fill_cnt_d    = fill_cnt;
    cur_x_d       = cur_x;
    finished_d    = finished;
    error_d       = 1'b0;
    plot_d        = 1'b0;
    mem_write_d   = 1'b0;
    result_d      = result;
    x_d           = x;
    y_d           = y;
    colour_d      = colour;
    mem_address_d = mem_address;
    mem_data_d    = mem_data;
    case (state)
      S_IDLE: begin
        if (finished) begin
          if (start) begin
            instr_d    = instruction;
            finished_d = 1'b0;
            wait_cnt_d = '0;
            fill_cnt_d = f_count;
            cur_x_d    = f_x;
            case (f_op)
              OP_DRAW:     state_d = S_DRAW;
              OP_MEMREAD:  state_d = S_RD_WAIT;
              OP_MEMWRITE: state_d = S_WR;
              OP_FILL:     if (f_count != '0) state_d = S_FILL;
              OP_MEMADD:   state_d = S_ADD_WAIT;
              default:     state_d = S_IDLE;
            endcase
          end
        end else begin
          // Shared completion edge for NOP, illegal, DRAW, MEMWRITE and FILL.
          finished_d = 1'b1;
          error_d    = !f_legal;
        end
      end
      S_DRAW: begin
        x_d      = f_x;
        y_d      = f_y;
        colour_d = f_colour;
        plot_d   = f_plot;
        state_d  = S_IDLE;
      end
      S_RD_WAIT: begin
        if (wait_cnt == '0) mem_address_d = f_addr;
        if (wait_cnt == CW'(RD_LAT)) begin
          result_d   = RESULT_W'(mem_q);
          finished_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      S_ADD_WAIT: begin
        if (wait_cnt == '0) mem_address_d = f_addr;
        if (wait_cnt == CW'(RD_LAT)) begin
          mem_data_d  = sum;
          mem_write_d = 1'b1;
          result_d    = RESULT_W'(sum);
          state_d     = S_ADD_WR;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      S_ADD_WR: begin
        finished_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_WR: begin
        mem_address_d = f_addr;
        mem_data_d    = f_data;
        mem_write_d   = 1'b1;
        state_d       = S_IDLE;
      end
      S_FILL: begin
        x_d        = cur_x;
        y_d        = f_y;
        colour_d   = f_colour;
        plot_d     = 1'b1;
        cur_x_d    = cur_x + 1'b1;
        fill_cnt_d = fill_cnt - 1'b1;
        if (fill_cnt == CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      wait_cnt    <= '0;
      fill_cnt    <= '0;
      cur_x       <= '0;
      finished    <= 1'b1;
      error       <= 1'b0;
      plot        <= 1'b0;
      mem_write   <= 1'b0;
      result      <= '0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      state       <= state_d;
      instr_q     <= instr_d;
      wait_cnt    <= wait_cnt_d;
      fill_cnt    <= fill_cnt_d;
      cur_x       <= cur_x_d;
      finished    <= finished_d;
      error       <= error_d;
      plot        <= plot_d;
      mem_write   <= mem_write_d;
      result      <= result_d;
      x           <= x_d;
      y           <= y_d;
      colour      <= colour_d;
      mem_address <= mem_address_d;
      mem_data    <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb/tb_instr_exec_unit.sv - directed self-checking bench for instr_exec_unit
module tb_instr_exec_unit;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instruction = '0;
  logic        finished, error, plot, mem_write;
  logic [15:0] result;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic [15:0] mem_address;
  logic [11:0] mem_data;
  logic [11:0] mem_q;
  logic [11:0] ram [0:65535];

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  instr_exec_unit dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .instruction(instruction),
    .finished   (finished),
    .error      (error),
    .result     (result),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_write  (mem_write),
    .mem_q      (mem_q)
  );

  // Synchronous RAM with registered output: with RD_LAT=2 the word is sampled two edges after the address edge.
  always @(posedge clock) begin
    if (mem_write) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a request, let the acceptance edge E0 pass, then scramble the input bus.
  task automatic issue(input logic [31:0] v);
    start = 1'b1;
    instruction = v;
    tick();
    start = 1'b0;
    instruction = 32'hFFFF_FFFF;
  endtask

  task automatic memadd_case(input logic [31:0] v, input logic [15:0] a, input logic [11:0] s);
    issue(v);
    chk("add_e0_fin", 32'(finished), 32'd0);
    tick();
    chk("add_e1_addr", 32'(mem_address), 32'(a));
    chk("add_e1_wr", 32'(mem_write), 32'd0);
    tick();
    chk("add_e2_wr", 32'(mem_write), 32'd0);
    tick();
    chk("add_e3_wr", 32'(mem_write), 32'd1);
    chk("add_e3_data", 32'(mem_data), 32'(s));
    chk("add_e3_result", 32'(result), 32'(s));
    chk("add_e3_fin", 32'(finished), 32'd0);
    tick();
    chk("add_e4_wr", 32'(mem_write), 32'd0);
    chk("add_e4_fin", 32'(finished), 32'd1);
    chk("add_ram", 32'(ram[a]), 32'(s));
  endtask

  task automatic draw_case();
    issue(32'h1006_940A);
    chk("draw_e0_fin", 32'(finished), 32'd0);
    chk("draw_e0_plot", 32'(plot), 32'd0);
    tick();
    chk("draw_e1_x", 32'(x), 32'd10);
    chk("draw_e1_y", 32'(y), 32'd20);
    chk("draw_e1_colour", 32'(colour), 32'd5);
    chk("draw_e1_plot", 32'(plot), 32'd1);
    chk("draw_e1_fin", 32'(finished), 32'd0);
    tick();
    chk("draw_e2_plot", 32'(plot), 32'd0);
    chk("draw_e2_fin", 32'(finished), 32'd1);
    chk("draw_e2_x_hold", 32'(x), 32'd10);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = '0;
    repeat (2) tick();
    chk("rst_finished", 32'(finished), 32'd1);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    tick();

    draw_case();

    // FILL of 8 pixels from x=250, with a stray start pulse that must be ignored.
    issue(32'h4041_03FA);
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] ex;
      ex = 8'(250 + i - 1);
      if (i == 3) begin
        start = 1'b1;
        instruction = 32'h1006_940A;
      end
      tick();
      start = 1'b0;
      chk("fill_plot", 32'(plot), 32'd1);
      chk("fill_x", 32'(x), 32'(ex));
      chk("fill_y", 32'(y), 32'd3);
      chk("fill_colour", 32'(colour), 32'd2);
      chk("fill_fin", 32'(finished), 32'd0);
    end
    tick();
    chk("fill_e9_plot", 32'(plot), 32'd0);
    chk("fill_e9_fin", 32'(finished), 32'd1);

    issue(32'h3ABC_0123);
    tick();
    chk("wr_e1_wr", 32'(mem_write), 32'd1);
    chk("wr_e1_addr", 32'(mem_address), 32'h123);
    chk("wr_e1_data", 32'(mem_data), 32'hABC);
    chk("wr_e1_fin", 32'(finished), 32'd0);
    tick();
    chk("wr_e2_wr", 32'(mem_write), 32'd0);
    chk("wr_e2_fin", 32'(finished), 32'd1);

    issue(32'h2000_0123);
    tick();
    chk("rd_e1_addr", 32'(mem_address), 32'h123);
    chk("rd_e1_wr", 32'(mem_write), 32'd0);
    tick();
    chk("rd_e2_fin", 32'(finished), 32'd0);
    tick();
    chk("rd_e3_result", 32'(result), 32'h0ABC);
    chk("rd_e3_fin", 32'(finished), 32'd1);

    memadd_case(32'h5005_0123, 16'h0123, 12'hAC1);

    issue(32'h3FFF_0124);
    repeat (2) tick();
    memadd_case(32'h5001_0124, 16'h0124, 12'h000);

    issue(32'hF000_0000);
    chk("ill_e0_err", 32'(error), 32'd0);
    tick();
    chk("ill_e1_err", 32'(error), 32'd1);
    chk("ill_e1_fin", 32'(finished), 32'd1);
    tick();
    chk("ill_e2_err", 32'(error), 32'd0);

    issue(32'h0000_0000);
    tick();
    chk("nop_e1_fin", 32'(finished), 32'd1);
    chk("nop_e1_err", 32'(error), 32'd0);
    tick();

    issue(32'h4000_0005);
    tick();
    chk("fill0_e1_fin", 32'(finished), 32'd1);
    chk("fill0_e1_plot", 32'(plot), 32'd0);
    tick();

    // Reset dropped between edges must clear outputs without waiting for a clock.
    issue(32'h4041_03FA);
    repeat (2) tick();
    chk("rstfill_pre_plot", 32'(plot), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rstfill_plot", 32'(plot), 32'd0);
    chk("rstfill_fin", 32'(finished), 32'd1);
    chk("rstfill_x", 32'(x), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    tick();

    issue(32'h3ABC_0125);
    tick();
    chk("rstwr_pre_wr", 32'(mem_write), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rstwr_wr", 32'(mem_write), 32'd0);
    chk("rstwr_fin", 32'(finished), 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    tick();

    draw_case();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
